// File: rtl/sc_run_controller.sv
// rtl/sc_run_controller.sv - run/step/breakpoint clock-enable sequencer for the single-cycle CPU
// Debounces the run/step/halt buttons and gates cpu_en so the CPU can free-run, step or trap on a PC.
module sc_run_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run_key,
  input  logic             step_key,
  input  logic             halt_key,
  input  logic             bp_enable,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       run_state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  logic [2:0] keys;
  logic [2:0] pulse;
  assign keys = {halt_key, step_key, run_key};

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_key
      logic          sync1, sync2, level, level_q;
      logic [DW-1:0] cnt;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          sync1   <= 1'b0;
          sync2   <= 1'b0;
          level   <= 1'b0;
          level_q <= 1'b0;
          cnt     <= '0;
        end else begin
          sync1   <= keys[k];
          sync2   <= sync1;
          level_q <= level;
          if (sync2 == level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
      end

      assign pulse[k] = level & ~level_q;
    end
  endgenerate

  state_t state_q, state_d;
  logic   skip_q, skip_d;
  logic   bp_hit_q, bp_hit_d;
  logic   halt_p, step_p, run_p, bp_match;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_HALT;
      skip_q      <= 1'b0;
      bp_hit_q    <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
      if (cpu_en) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    bp_hit_d = bp_hit_q;
    // only the highest-priority pulse acts
    halt_p   = pulse[2];
    step_p   = pulse[1] & ~pulse[2];
    run_p    = pulse[0] & ~pulse[1] & ~pulse[2];
    bp_match = bp_enable & (pc == bp_addr) & ~skip_q;
    cpu_en   = ((state_q == S_RUN) & ~bp_match) | (state_q == S_STEP);
    case (state_q)
      S_HALT: begin
        if (step_p) begin
          state_d = S_STEP;
        end else if (run_p) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      S_STEP: begin
        state_d  = S_HALT;
        bp_hit_d = 1'b0;
        skip_d   = 1'b0;
      end
      S_RUN: begin
        skip_d = 1'b0;
        if (halt_p) begin
          state_d = S_HALT;
        end else if (bp_match) begin
          state_d  = S_BREAK;
          bp_hit_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (halt_p) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b0;
        end else if (step_p) begin
          state_d = S_STEP;
        end else if (run_p) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  assign run_state = state_q;
  assign halted    = (state_q == S_HALT) | (state_q == S_BREAK);
  assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_sc_run_controller.sv
// tb/tb_sc_run_controller.sv - scoreboard bench for sc_run_controller with a cycle-level reference model
module tb_sc_run_controller;

  localparam int D    = 4;
  localparam int HALT = 0;
  localparam int RUN  = 1;
  localparam int STEP = 2;
  localparam int BRK  = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run_key = 1'b0, step_key = 1'b0, halt_key = 1'b0, bp_enable = 1'b0;
  logic [31:0] bp_addr = 32'd0, pc = 32'd0;
  logic        cpu_en, halted, bp_hit;
  logic [1:0]  run_state;
  logic [31:0] cycle_count;

  sc_run_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(32)) dut (
    .clock(clock), .resetn(resetn), .run_key(run_key), .step_key(step_key),
    .halt_key(halt_key), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .run_state(run_state), .halted(halted), .bp_hit(bp_hit),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        en;
    bit [1:0]  st;
    bit        hl;
    bit        bp;
    bit [31:0] cnt;
    int        idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_fail = 0;
  int   en_seen = 0, en_idx = -1, cyc_idx = 0;

  // reference model: run state, sticky flags, and per-key "raw delayed two edges, stable D edges" filter
  int        m_st = HALT;
  bit        m_skip = 0, m_bp = 0;
  bit [31:0] m_cnt = 0;
  bit        lvl[3], d1[3], d2[3], m_p[3];
  int        run_len[3];
  bit        nbp_en = 0, pc_load = 0;
  bit [31:0] nbp_addr = 0, pc_next = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit exp_en();
    return (m_st == RUN && !(bp_enable && pc == bp_addr && !m_skip)) || m_st == STEP;
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.en  = exp_en();
    e.st  = 2'(m_st);
    e.hl  = (m_st == HALT) || (m_st == BRK);
    e.bp  = m_bp;
    e.cnt = m_cnt;
    e.idx = cyc_idx;
    sb.push_back(e);
  endfunction

  task automatic model_edge();
    bit en, match, hp, sp, rp;
    bit raw[3];
    en    = exp_en();
    match = bp_enable && pc == bp_addr && !m_skip;
    pc_next = en ? ((pc + 32'd4) & 32'h1F) : pc;
    if (en) m_cnt++;
    hp = m_p[2];
    sp = m_p[1] && !m_p[2];
    rp = m_p[0] && !m_p[1] && !m_p[2];
    case (m_st)
      HALT: if (sp) m_st = STEP; else if (rp) begin m_st = RUN; m_skip = 1; end
      STEP: begin m_st = HALT; m_bp = 0; m_skip = 0; end
      RUN: begin
        m_skip = 0;
        if (hp) m_st = HALT;
        else if (match) begin m_st = BRK; m_bp = 1; end
      end
      default: begin
        if (hp) begin m_st = HALT; m_bp = 0; end
        else if (sp) m_st = STEP;
        else if (rp) begin m_st = RUN; m_skip = 1; end
      end
    endcase
    raw = '{run_key, step_key, halt_key};
    for (int k = 0; k < 3; k++) begin
      m_p[k] = 0;
      if (d2[k] != lvl[k]) begin
        run_len[k]++;
        if (run_len[k] == D) begin
          lvl[k]     = d2[k];
          run_len[k] = 0;
          m_p[k]     = lvl[k];
        end
      end else begin
        run_len[k] = 0;
      end
      d2[k] = d1[k];
      d1[k] = raw[k];
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit h);
    @(posedge clock);
    model_edge();
    #1;
    run_key   = r;
    step_key  = s;
    halt_key  = h;
    bp_enable = nbp_en;
    bp_addr   = nbp_addr;
    pc        = pc_load ? 32'd0 : pc_next;
    pc_load   = 0;
    push_expected();
    cyc_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  task automatic wait_state(input int t, input int budget, input string name);
    int n = 0;
    while (m_st != t && n < budget) begin
      cyc(0, 0, 0);
      n++;
    end
    #1;
    chk(name, 64'(run_state), 64'(t));
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("cpu_en", 64'(cpu_en), 64'(mon_e.en));
      chk("run_state", 64'(run_state), 64'(mon_e.st));
      chk("halted", 64'(halted), 64'(mon_e.hl));
      chk("bp_hit", 64'(bp_hit), 64'(mon_e.bp));
      chk("cycle_count", 64'(cycle_count), 64'(mon_e.cnt));
      if (cpu_en === 1'b1) begin
        en_seen++;
        en_idx = mon_e.idx;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base, p0;
    for (int k = 0; k < 3; k++) begin
      lvl[k] = 0; d1[k] = 0; d2[k] = 0; m_p[k] = 0; run_len[k] = 0;
    end
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    push_expected();

    idle(100);
    #1;
    chk("reset_state", 64'(run_state), 64'(HALT));
    chk("reset_en", 64'(cpu_en), 64'd0);
    chk("reset_count", 64'(cycle_count), 64'd0);
    chk("reset_halted", 64'(halted), 64'd1);

    // key is sampled one edge after it is driven; pulse D+2 later, enable one edge after that
    base = en_seen;
    p0   = cyc_idx;
    repeat (10) cyc(0, 1, 0);
    idle(12);
    #1;
    chk("step_pulses", 64'(en_seen - base), 64'd1);
    chk("step_latency", 64'(en_idx - p0), 64'(D + 3));
    chk("step_count", 64'(cycle_count), 64'd1);
    chk("step_back_halt", 64'(run_state), 64'(HALT));

    base = en_seen;
    repeat (D - 1) cyc(0, 1, 0);
    idle(12);
    #1;
    chk("glitch_pulses", 64'(en_seen - base), 64'd0);
    chk("glitch_count", 64'(cycle_count), 64'd1);

    pc_load  = 1;
    nbp_en   = 1;
    nbp_addr = 32'h0C;
    idle(3);
    repeat (6) cyc(1, 0, 0);
    wait_state(BRK, 40, "bp_reach_break");
    chk("bp_hit_set", 64'(bp_hit), 64'd1);
    chk("bp_count", 64'(cycle_count), 64'd4);
    chk("bp_en_low", 64'(cpu_en), 64'd0);

    idle(10);
    repeat (5) cyc(1, 0, 0);
    wait_state(RUN, 20, "resume_run");
    wait_state(BRK, 40, "retrap_break");
    chk("retrap_count", 64'(cycle_count), 64'd12);
    chk("retrap_bp_hit", 64'(bp_hit), 64'd1);

    repeat (6) cyc(0, 0, 1);
    wait_state(HALT, 20, "break_to_halt");
    chk("halt_clears_bp", 64'(bp_hit), 64'd0);
    idle(10);
    repeat (6) cyc(1, 0, 1);
    idle(12);
    #1;
    chk("run_halt_same", 64'(run_state), 64'(HALT));
    chk("run_halt_count", 64'(cycle_count), 64'd12);

    for (int i = 0; i < 200; i++) begin
      int sel, hold, gap;
      bit r, s, h;
      sel = int'($urandom_range(0, 9));
      r = (sel <= 4) || sel >= 8;
      s = (sel == 5) || (sel == 6) || sel >= 8;
      h = (sel == 7) || (sel == 9);
      if ($urandom_range(0, 3) == 0) begin
        nbp_en   = 1'($urandom_range(0, 1));
        nbp_addr = 32'(4 * (1 + 2 * $urandom_range(0, 3)));
      end
      hold = int'($urandom_range(1, 9));
      gap  = int'($urandom_range(0, 12));
      repeat (hold) cyc(r, s, h);
      idle(gap);
    end

    nbp_en = 0;
    idle(12);
    repeat (6) cyc(0, 0, 1);
    wait_state(HALT, 30, "pre_reset_halt");
    idle(10);
    repeat (6) cyc(1, 0, 0);
    wait_state(RUN, 30, "pre_reset_run");
    idle(3);
    @(posedge clock);
    #2;
    chk("pre_reset_en", 64'(cpu_en), 64'd1);
    resetn = 1'b0;
    #1;
    chk("async_reset_en", 64'(cpu_en), 64'd0);
    chk("async_reset_state", 64'(run_state), 64'(HALT));
    chk("async_reset_halted", 64'(halted), 64'd1);
    chk("async_reset_bp", 64'(bp_hit), 64'd0);
    chk("async_reset_count", 64'(cycle_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
